// File: rtl/tcb_dma_arbiter_pkg.sv
// rtl/tcb_dma_arbiter_pkg.sv - shared types, widths and region defaults for the TCB/DMA arbiter
package tcb_dma_arbiter_pkg;

   // Address width and the widened width used for range comparisons (base+size must not wrap)
   localparam int ADDR_W = 16;
   localparam int CMP_W  = ADDR_W + 1;

   // Region defaults, shared with the protection monitor
   localparam logic [ADDR_W-1:0] DEF_PROTECTED_BASE = 16'h0010;
   localparam logic [ADDR_W-1:0] DEF_PROTECTED_SIZE = 16'h0010;
   localparam logic [ADDR_W-1:0] DEF_TCB_BASE       = 16'h0010;
   localparam logic [ADDR_W-1:0] DEF_TCB_SIZE       = 16'h0010;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_GRANT = 3'd1,
      ST_ERR   = 3'd2,
      ST_LOCK  = 3'd3,
      ST_GUARD = 3'd4
   } arb_state_t;

   // Exclusive end of a region, optionally pulled in by adj (TCB ends at its last instruction)
   function automatic logic [CMP_W-1:0] range_end(
      input logic [ADDR_W-1:0] base,
      input logic [ADDR_W-1:0] size,
      input logic [ADDR_W-1:0] adj
   );
      return {1'b0, base} + {1'b0, size} - {1'b0, adj};
   endfunction

endpackage

// File: rtl/tcb_range_check.sv
// rtl/tcb_range_check.sv - combinational address-in-[base, limit) comparator
module tcb_range_check
   import tcb_dma_arbiter_pkg::*;
#(
   parameter logic [CMP_W-1:0] BASE  = {1'b0, DEF_TCB_BASE},
   parameter logic [CMP_W-1:0] LIMIT = {1'b0, DEF_TCB_BASE} + {1'b0, DEF_TCB_SIZE}
)(
   input  logic [ADDR_W-1:0] addr,
   output logic              hit
);

   logic [CMP_W-1:0] addr_w;

   // Widen by one bit so limits at the top of the address space compare correctly
   always_comb begin
      addr_w = {1'b0, addr};
      hit    = (addr_w >= BASE) && (addr_w < LIMIT);
   end

endmodule

// File: rtl/tcb_dma_arbiter.sv
// rtl/tcb_dma_arbiter.sv - holds DMA off around TCB execution and refuses DMA into the protected region
module tcb_dma_arbiter
   import tcb_dma_arbiter_pkg::*;
#(
   parameter logic [15:0] PROTECTED_BASE = DEF_PROTECTED_BASE,
   parameter logic [15:0] PROTECTED_SIZE = DEF_PROTECTED_SIZE,
   parameter logic [15:0] TCB_BASE       = DEF_TCB_BASE,
   parameter logic [15:0] TCB_SIZE       = DEF_TCB_SIZE,
   parameter int          GUARD_CYCLES   = 4,
   parameter logic [15:0] MAX_WAIT       = 16'd1024
)(
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] pc,
   input  logic        dma_req,
   input  logic [15:0] dma_addr,
   input  logic        dma_we,
   output logic        dma_grant,
   output logic        dma_err,
   output logic        dma_en_o,
   output logic [15:0] dma_addr_o,
   output logic        tcb_busy,
   output logic        dma_starve
);

   // The TCB window ends at its last instruction (base+size-2), hence the end pulled in by one
   localparam logic [CMP_W-1:0] TCB_LO  = {1'b0, TCB_BASE};
   localparam logic [CMP_W-1:0] TCB_HI  = range_end(TCB_BASE, TCB_SIZE, 16'd1);
   localparam logic [CMP_W-1:0] PROT_LO = {1'b0, PROTECTED_BASE};
   localparam logic [CMP_W-1:0] PROT_HI = range_end(PROTECTED_BASE, PROTECTED_SIZE, 16'd0);
   localparam logic [3:0]       GUARD_LOAD = 4'(GUARD_CYCLES - 1);

   arb_state_t  state, state_d;
   logic [3:0]  guard_cnt, guard_d;
   logic [15:0] wait_cnt;
   logic        pc_in_tcb;
   logic        hit_prot;
   logic        ack;
   logic        unused_we;

   // Read/write direction does not affect arbitration; it travels with the request elsewhere
   assign unused_we = dma_we;

   tcb_range_check #(
      .BASE  (TCB_LO),
      .LIMIT (TCB_HI)
   ) u_pc_check (
      .addr (pc),
      .hit  (pc_in_tcb)
   );

   tcb_range_check #(
      .BASE  (PROT_LO),
      .LIMIT (PROT_HI)
   ) u_dma_check (
      .addr (dma_addr),
      .hit  (hit_prot)
   );

   // State and guard counter registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         guard_cnt <= 4'd0;
      end else begin
         state     <= state_d;
         guard_cnt <= guard_d;
      end
   end

   // Next-state and outputs; the bus enable is gated by pc_in_tcb in the same cycle so DMA never
   // touches memory while trusted code runs, even if pc jumps in as GRANT is registered
   always_comb begin
      state_d    = state;
      guard_d    = guard_cnt;
      dma_grant  = 1'b0;
      dma_err    = 1'b0;
      dma_en_o   = 1'b0;
      dma_addr_o = 16'h0000;
      case (state)
         ST_IDLE: begin
            if (pc_in_tcb) begin
               state_d = ST_LOCK;
            end else if (dma_req && hit_prot) begin
               state_d = ST_ERR;
            end else if (dma_req) begin
               state_d = ST_GRANT;
            end
         end
         ST_GRANT: begin
            // A dropped request or one retargeted into the protected region gets no access
            if (!pc_in_tcb && dma_req && !hit_prot) begin
               dma_en_o   = 1'b1;
               dma_grant  = 1'b1;
               dma_addr_o = dma_addr;
            end
            state_d = pc_in_tcb ? ST_LOCK : ST_IDLE;
         end
         ST_ERR: begin
            dma_err = dma_req;
            state_d = pc_in_tcb ? ST_LOCK : ST_IDLE;
         end
         ST_LOCK: begin
            if (!pc_in_tcb) begin
               state_d = ST_GUARD;
               guard_d = GUARD_LOAD;
            end
         end
         ST_GUARD: begin
            if (pc_in_tcb) begin
               state_d = ST_LOCK;
            end else if (guard_cnt == 4'd0) begin
               state_d = ST_IDLE;
            end else begin
               guard_d = guard_cnt - 4'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign tcb_busy = (state == ST_LOCK) || (state == ST_GUARD);
   assign ack      = dma_grant || dma_err;

   // Waiting-cycle counter: counts unacked request cycles, saturates at MAX_WAIT
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wait_cnt <= 16'd0;
      end else if (!dma_req || ack) begin
         wait_cnt <= 16'd0;
      end else if (wait_cnt != MAX_WAIT) begin
         wait_cnt <= wait_cnt + 16'd1;
      end
   end

   // Sticky starvation flag, released only by the next successful grant
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dma_starve <= 1'b0;
      end else if (dma_grant) begin
         dma_starve <= 1'b0;
      end else if (wait_cnt == MAX_WAIT) begin
         dma_starve <= 1'b1;
      end
   end

endmodule

// File: tb/tb_tcb_dma_arbiter.sv
// tb/tb_tcb_dma_arbiter.sv - scoreboard bench for tcb_dma_arbiter
module tb_tcb_dma_arbiter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic [15:0] pc = 16'hE000;
   logic        dma_req = 1'b0;
   logic [15:0] dma_addr = 16'h0000;
   logic        dma_we = 1'b0;
   logic        dma_grant;
   logic        dma_err;
   logic        dma_en_o;
   logic [15:0] dma_addr_o;
   logic        tcb_busy;
   logic        dma_starve;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        is_err;
      logic [15:0] addr;
      int          cyc;
   } exp_t;

   exp_t sb[$];

   tcb_dma_arbiter #(.MAX_WAIT(16'd8)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .pc         (pc),
      .dma_req    (dma_req),
      .dma_addr   (dma_addr),
      .dma_we     (dma_we),
      .dma_grant  (dma_grant),
      .dma_err    (dma_err),
      .dma_en_o   (dma_en_o),
      .dma_addr_o (dma_addr_o),
      .tcb_busy   (tcb_busy),
      .dma_starve (dma_starve)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic bit tb_in_tcb(input logic [15:0] p);
      return (p >= 16'h0010) && (p <= 16'h001E);
   endfunction

   // Monitor: checks every ack against the scoreboard and the bus-enable invariant every cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         checks++;
         if (dma_en_o && tb_in_tcb(pc)) begin
            errors++;
            $display("FAIL en_in_tcb: dma_en_o=1 with pc=%h at cycle %0d, required 0", pc, cyc);
         end
         if (dma_grant || dma_err) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_ack: grant=%b err=%b addr_o=%h at cycle %0d, required no ack",
                        dma_grant, dma_err, dma_addr_o, cyc);
            end else begin
               e = sb.pop_front();
               if (dma_err !== e.is_err || dma_grant !== !e.is_err || cyc != e.cyc ||
                   dma_en_o !== !e.is_err || dma_addr_o !== (e.is_err ? 16'h0000 : e.addr)) begin
                  errors++;
                  $display("FAIL ack_%h: got grant=%b err=%b en=%b addr_o=%h cycle=%0d, required err=%b addr_o=%h cycle=%0d",
                           e.addr, dma_grant, dma_err, dma_en_o, dma_addr_o, cyc,
                           e.is_err, e.is_err ? 16'h0000 : e.addr, e.cyc);
               end
            end
         end
      end
   end

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h at cycle %0d", name, act, req, cyc);
      end
   endtask

   task automatic expect_ack(input logic is_err, input logic [15:0] addr, input int at);
      exp_t e;
      e.is_err = is_err;
      e.addr   = addr;
      e.cyc    = at;
      sb.push_back(e);
   endtask

   // Hold the request until an ack appears, then release it one cycle later
   task automatic wait_ack_drop();
      int n = 0;
      while (!(dma_grant || dma_err) && n < 64) begin
         tick();
         n++;
      end
      if (n >= 64) begin
         checks++;
         errors++;
         $display("FAIL ack_timeout: no ack within 64 cycles at cycle %0d, required an ack", cyc);
      end
      tick();
      dma_req = 1'b0;
   endtask

   task automatic do_req(input logic [15:0] addr, input logic is_err, input logic we);
      expect_ack(is_err, addr, cyc + 1);
      dma_addr = addr;
      dma_we   = we;
      dma_req  = 1'b1;
      wait_ack_drop();
   endtask

   initial begin
      int c;
      reset_n = 1'b0;
      #1;
      check("rst_grant", dma_grant, 0);
      check("rst_err", dma_err, 0);
      check("rst_en", dma_en_o, 0);
      check("rst_addr_o", dma_addr_o, 0);
      check("rst_busy", tcb_busy, 0);
      check("rst_starve", dma_starve, 0);
      tick(2);
      reset_n = 1'b1;
      tick();

      // Plain grant, protected error, region edges, back-to-back
      do_req(16'h0200, 1'b0, 1'b0);
      do_req(16'h0014, 1'b1, 1'b1);
      do_req(16'h000F, 1'b0, 1'b1);
      do_req(16'h0010, 1'b1, 1'b0);
      do_req(16'h001F, 1'b1, 1'b0);
      do_req(16'h0020, 1'b0, 1'b1);
      pc = 16'h001F;
      do_req(16'h0202, 1'b0, 1'b0);
      pc = 16'h000F;
      do_req(16'h0204, 1'b0, 1'b0);
      pc = 16'hE000;
      tick();

      // pc enters the TCB as GRANT is registered: no access, lock, 4-cycle guard, then retry
      c = cyc;
      expect_ack(1'b0, 16'h0300, c + 10);
      dma_addr = 16'h0300;
      dma_req  = 1'b1;
      tick();
      pc = 16'h0010;
      #1;
      check("blocked_en", dma_en_o, 0);
      check("blocked_grant", dma_grant, 0);
      tick();
      check("lock_busy", tcb_busy, 1);
      tick(2);
      pc = 16'hE000;
      tick(4);
      check("guard_last_busy", tcb_busy, 1);
      tick();
      check("guard_done_busy", tcb_busy, 0);
      wait_ack_drop();

      // Re-entry at guard cycle 2 restarts the full guard window
      c = cyc;
      expect_ack(1'b0, 16'h0400, c + 11);
      pc       = 16'h001E;
      dma_addr = 16'h0400;
      dma_req  = 1'b1;
      tick(2);
      pc = 16'hE000;
      tick();
      check("guard1_busy", tcb_busy, 1);
      tick();
      pc = 16'h001E;
      tick();
      check("relock_busy", tcb_busy, 1);
      pc = 16'hE000;
      wait_ack_drop();
      check("starve_cleared_prev", dma_starve, 0);

      // Starvation with MAX_WAIT=8, sticky until the next grant
      c = cyc;
      expect_ack(1'b0, 16'h0500, c + 16);
      pc       = 16'h0010;
      dma_addr = 16'h0500;
      dma_req  = 1'b1;
      tick(7);
      check("starve_early", dma_starve, 0);
      tick(3);
      check("starve_set", dma_starve, 1);
      pc = 16'hE000;
      tick(5);
      check("starve_held", dma_starve, 1);
      wait_ack_drop();
      check("starve_clear", dma_starve, 0);

      // Asynchronous reset while in GRANT drops the pending grant
      dma_addr = 16'h0600;
      dma_req  = 1'b1;
      tick();
      check("pre_reset_grant", dma_grant, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_grant", dma_grant, 0);
      check("async_en", dma_en_o, 0);
      check("async_addr_o", dma_addr_o, 0);
      check("async_err", dma_err, 0);
      check("async_busy", tcb_busy, 0);
      dma_req = 1'b0;
      tick(2);
      reset_n = 1'b1;
      tick(4);
      check("post_reset_busy", tcb_busy, 0);
      do_req(16'h0700, 1'b0, 1'b1);
      tick(2);

      check("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
